crossy_game_ctrl: RTL and testbench
===================================

// Module: crossy_game_ctrl
// PURPOSE
//  Frame-rate game sequencer for the VGA crossy-road game. Sits between the vga timing
//  generator and the pixel renderer: steps the player FSM on button presses, advances
//  per-lane car positions once per frame, latches renderer-reported collisions, and
//  keeps the score. All outputs are registers consumed by the renderer.
// PARAMETERS
//  NUM_LANES   8    lanes incl. start (lane 0) and goal (lane NUM_LANES-1); 2..16
//  HOP_FRAMES  8    frames per hop animation; 1..15
//  DEAD_FRAMES 60   frames the DEAD state is held before returning to IDLE; 1..255
//  H_ACTIVE    640  car x wrap modulus (pixels)
// PORTS
//  clk          in   1               pixel clock
//  sys_rst      in   1               synchronous, active-high reset
//  move         in   1               raw hop button, asynchronous, active-high
//  vsync        in   1               from vga, active-low pulse
//  display_on   in   1               from vga, active video
//  hit_pixel    in   1               renderer: player and car both drawn at current pixel
//  game_state   out  2               0 IDLE, 1 PLAY, 2 HOP, 3 DEAD
//  player_lane  out  4               current lane of player
//  hop_offset   out  4               animation step within a hop, 0 when not hopping
//  car_x        out  10*NUM_LANES    packed car x per lane, lane i at [10*i +: 10]
//  score        out  8               goals reached, saturating
// BEHAVIOUR
//  - Reset: game_state=0, player_lane=0, hop_offset=0, score=0, car_x[i]=(i*80) mod H_ACTIVE,
//    hit flag=0, dead counter=0, synchronizer/edge regs=0.
//  - move: 2-flop synchronizer + rising-edge detect -> 1-cycle press pulse. Rising edge
//    of move before clk edge k gives press at cycle k+2; state reacts at edge k+3.
//  - frame_tick: 1-cycle pulse on the cycle after registered vsync goes 1->0.
//  - Cars: on frame_tick in states 0..2, lane i moves by 1+(i mod 4); even lanes +,
//    odd lanes -; wrap mod H_ACTIVE (639+1 -> 0, 0-1 -> 639). Frozen in DEAD.
//  - Hit flag: set on any cycle with hit_pixel & display_on in PLAY or HOP; cleared on
//    each frame_tick (after being evaluated) and on any entry to IDLE.
//  - FSM (all transitions on clk edge):
//    IDLE: press -> PLAY, score=0, player_lane=0.
//    PLAY: frame_tick & hit -> DEAD (priority); else press -> HOP, hop_offset=0.
//    HOP : press ignored. frame_tick & hit -> DEAD (priority, hop_offset=0).
//          else frame_tick: if hop_offset==HOP_FRAMES-1 -> hop_offset=0, player_lane+1;
//          if new lane==NUM_LANES-1 -> score+1 (saturate 255), player_lane=0; -> PLAY.
//          otherwise hop_offset+1, stay HOP.
//    DEAD: press ignored; dead counter counts frame_ticks; at DEAD_FRAMES-th tick -> IDLE,
//          player_lane=0, counter=0. score held for display until next IDLE press.
//  - Simultaneous press and frame_tick in PLAY (no hit): enter HOP with hop_offset=0; the
//    tick still moves cars; the hop's first advance is the following tick.
//  - Only one hop per press; button held does not repeat.
//  - sys_rst mid-hop or mid-DEAD: all state to reset values at that edge, no score change.
// TESTING
//  1 Reset, no vsync: car_x lane0..7 = 0,80,...,560; state 0; score 0; lane 0.
//  2 Press in IDLE -> state 1 three clks after move rises; hold move 1000 clks -> one press only.
//  3 PLAY, press, 8 frame_ticks, no hits -> hop_offset 0..7 then lane 1, state PLAY.
//  4 Seven hops with no hits -> score 1, lane 0; force score 255 + goal -> stays 255.
//  5 Lane1 car at 0, one frame_tick -> 638; lane0 car at 639 -> 0 after tick.
//  6 hit_pixel pulse with display_on in HOP -> DEAD at next tick, cars frozen 60 ticks, then IDLE.

Source files
------------

// File: rtl/crossy_game_ctrl.sv
// -----------------------------------------------------------------------------
// crossy_game_ctrl
//   Frame-rate game sequencer for the VGA crossy-road game. It sits between the
//   VGA timing generator and the pixel renderer. It steps the player FSM on
//   button presses, advances the per-lane car positions once per frame, latches
//   renderer-reported collisions and keeps the score. Every output comes
//   straight from a register.
//
// Ports
//   clk          in   pixel clock
//   sys_rst      in   synchronous, active-high reset
//   move         in   raw hop button (asynchronous, active-high)
//   vsync        in   VGA vertical sync (active-low pulse)
//   display_on   in   VGA active-video flag
//   hit_pixel    in   renderer: player and a car are drawn on the current pixel
//   game_state   out  0 IDLE, 1 PLAY, 2 HOP, 3 DEAD (also the FSM debug view)
//   player_lane  out  current lane of the player
//   hop_offset   out  animation step inside a hop, 0 when not hopping
//   car_x        out  packed car x per lane, lane i at [10*i +: 10]
//   score        out  goals reached, saturating at 255
//
// Pulse semantics (there is no valid/ready handshake in this block):
//   press_q    is high for exactly one cycle per rising edge of the synchronized
//              button, so holding the button never repeats a hop.
//   frame_tick is high for exactly one cycle after registered vsync falls.
//   Every state change happens on a clk edge where the pulse is high.
// -----------------------------------------------------------------------------
module crossy_game_ctrl #(
   parameter int NUM_LANES   = 8,
   parameter int HOP_FRAMES  = 8,
   parameter int DEAD_FRAMES = 60,
   parameter int H_ACTIVE    = 640
) (
   input  logic                      clk,
   input  logic                      sys_rst,
   input  logic                      move,
   input  logic                      vsync,
   input  logic                      display_on,
   input  logic                      hit_pixel,
   output logic [1:0]                game_state,
   output logic [3:0]                player_lane,
   output logic [3:0]                hop_offset,
   output logic [10*NUM_LANES-1:0]   car_x,
   output logic [7:0]                score
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_HOP  = 2'd2,
      S_DEAD = 2'd3
   } state_t;

   state_t     state_q;
   logic [3:0] lane_q;
   logic [3:0] hop_q;
   logic [7:0] score_q;
   logic [7:0] dead_cnt_q;
   logic       hit_q;

   logic       sync1_q, sync2_q, sync3_q, press_q;
   logic       vs_q, vs_d1_q;
   logic       frame_tick;

   logic [9:0] car_q [NUM_LANES];
   logic [9:0] car_d [NUM_LANES];

   // Registered vsync has just gone 1 -> 0.
   assign frame_tick = vs_d1_q & ~vs_q;

   // One car step for a lane: speed 1 + (lane mod 4), even lanes move right,
   // odd lanes move left, both wrap modulo H_ACTIVE.
   function automatic logic [9:0] car_step(input logic [9:0] x, input int unsigned lane);
      logic [10:0] spd;
      logic [10:0] wide;
      spd = 11'(1 + (lane % 4));
      if ((lane % 2) == 0) begin
         wide = {1'b0, x} + spd;
         if (wide >= 11'(H_ACTIVE)) wide = wide - 11'(H_ACTIVE);
      end else begin
         wide = {1'b0, x};
         if (wide < spd) wide = wide + 11'(H_ACTIVE);
         wide = wide - spd;
      end
      return wide[9:0];
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         car_d[i] = car_step(car_q[i], i);
      end
   end

   // Cars advance once per frame except while the player is dead.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         for (int i = 0; i < NUM_LANES; i++) car_q[i] <= 10'((i * 80) % H_ACTIVE);
      end else if (frame_tick && (state_q != S_DEAD)) begin
         for (int i = 0; i < NUM_LANES; i++) car_q[i] <= car_d[i];
      end
   end

   // Input conditioning and the game FSM.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         press_q    <= 1'b0;
         vs_q       <= 1'b0;
         vs_d1_q    <= 1'b0;
         hit_q      <= 1'b0;
         state_q    <= S_IDLE;
         lane_q     <= 4'd0;
         hop_q      <= 4'd0;
         score_q    <= 8'd0;
         dead_cnt_q <= 8'd0;
      end else begin
         sync1_q <= move;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         press_q <= sync2_q & ~sync3_q;
         vs_q    <= vsync;
         vs_d1_q <= vs_q;

         // The tick evaluates the flag this edge, so clearing here is safe; a
         // hit seen in the same cycle survives into the next frame.
         if (frame_tick) hit_q <= 1'b0;
         if (hit_pixel && display_on && ((state_q == S_PLAY) || (state_q == S_HOP)))
            hit_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (press_q) begin
                  state_q <= S_PLAY;
                  score_q <= 8'd0;
                  lane_q  <= 4'd0;
               end
            end
            S_PLAY: begin
               if (frame_tick && hit_q) begin
                  state_q <= S_DEAD;
               end else if (press_q) begin
                  state_q <= S_HOP;
                  hop_q   <= 4'd0;
               end
            end
            S_HOP: begin
               if (frame_tick) begin
                  if (hit_q) begin
                     state_q <= S_DEAD;
                     hop_q   <= 4'd0;
                  end else if (hop_q == 4'(HOP_FRAMES - 1)) begin
                     hop_q   <= 4'd0;
                     state_q <= S_PLAY;
                     // Landing on the goal lane scores and restarts at lane 0.
                     if (lane_q == 4'(NUM_LANES - 2)) begin
                        lane_q <= 4'd0;
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                     end else begin
                        lane_q <= lane_q + 4'd1;
                     end
                  end else begin
                     hop_q <= hop_q + 4'd1;
                  end
               end
            end
            S_DEAD: begin
               if (frame_tick) begin
                  if (dead_cnt_q == 8'(DEAD_FRAMES - 1)) begin
                     state_q    <= S_IDLE;
                     lane_q     <= 4'd0;
                     dead_cnt_q <= 8'd0;
                     hit_q      <= 1'b0;
                  end else begin
                     dead_cnt_q <= dead_cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      car_x = '0;
      for (int i = 0; i < NUM_LANES; i++) car_x[10*i +: 10] = car_q[i];
   end

   assign game_state  = state_q;
   assign player_lane = lane_q;
   assign hop_offset  = hop_q;
   assign score       = score_q;

endmodule

// File: tb/tb_crossy_game_ctrl.sv
module tb_crossy_game_ctrl;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        move = 1'b0;
   logic        vsync = 1'b1;
   logic        display_on = 1'b0;
   logic        hit_pixel = 1'b0;
   logic [1:0]  game_state;
   logic [3:0]  player_lane;
   logic [3:0]  hop_offset;
   logic [79:0] car_x;
   logic [7:0]  score;

   int errors = 0;
   int checks = 0;

   // Hand-computed car positions after n frame ticks counted from reset.
   int exp_n0 [8] = '{0, 80, 160, 240, 320, 400, 480, 560};
   int exp_n1 [8] = '{1, 78, 163, 236, 321, 398, 483, 556};
   int exp_n4 [8] = '{4, 72, 172, 224, 324, 392, 492, 544};
   int exp_n5 [8] = '{5, 70, 175, 220, 325, 390, 495, 540};

   crossy_game_ctrl dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .move        (move),
      .vsync       (vsync),
      .display_on  (display_on),
      .hit_pixel   (hit_pixel),
      .game_state  (game_state),
      .player_lane (player_lane),
      .hop_offset  (hop_offset),
      .car_x       (car_x),
      .score       (score)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      sys_rst = 1'b1;
      repeat (2) @(negedge clk);
      sys_rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // ---------------- drivers ----------------
   // One frame tick; on return the tick has been acted on.
   task automatic tick();
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
   endtask

   // One button press; on return the FSM has reacted to it.
   task automatic press();
      move = 1'b1;
      @(negedge clk);
      move = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_hop();
      press();
      repeat (8) tick();
   endtask

   task automatic pulse_hit(input logic disp);
      display_on = disp;
      hit_pixel  = 1'b1;
      @(negedge clk);
      display_on = 1'b0;
      hit_pixel  = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
      checks++; if (player_lane !== 4'd0) begin errors++; $display("FAIL reset_lane: got %0d expected 0", player_lane); end
      checks++; if (hop_offset !== 4'd0) begin errors++; $display("FAIL reset_hop: got %0d expected 0", hop_offset); end
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (car_x[10*i +: 10] !== 10'(exp_n0[i])) begin
            errors++; $display("FAIL reset_car%0d: got %0d expected %0d", i, car_x[10*i +: 10], exp_n0[i]);
         end
      end
   endtask

   task automatic test_press_hold();
      move = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL press_early: got %0d expected 0", game_state); end
      @(negedge clk);
      checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL press_play: got %0d expected 1", game_state); end
      repeat (1000) @(negedge clk);
      checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL hold_no_repeat: got %0d expected 1", game_state); end
      move = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_hop();
      press();
      checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL hop_enter: got %0d expected 2", game_state); end
      checks++; if (hop_offset !== 4'd0) begin errors++; $display("FAIL hop_off0: got %0d expected 0", hop_offset); end
      for (int k = 1; k < 8; k++) begin
         tick();
         checks++;
         if (hop_offset !== 4'(k) || game_state !== 2'd2) begin
            errors++; $display("FAIL hop_step%0d: got off=%0d st=%0d expected off=%0d st=2", k, hop_offset, game_state, k);
         end
      end
      tick();
      checks++;
      if (player_lane !== 4'd1 || game_state !== 2'd1 || hop_offset !== 4'd0) begin
         errors++; $display("FAIL hop_land: got lane=%0d st=%0d off=%0d expected 1 1 0", player_lane, game_state, hop_offset);
      end
   endtask

   task automatic test_goal();
      repeat (5) do_hop();
      checks++;
      if (player_lane !== 4'd6 || score !== 8'd0) begin
         errors++; $display("FAIL goal_pre: got lane=%0d score=%0d expected 6 0", player_lane, score);
      end
      do_hop();
      checks++;
      if (player_lane !== 4'd0 || score !== 8'd1 || game_state !== 2'd1) begin
         errors++; $display("FAIL goal: got lane=%0d score=%0d st=%0d expected 0 1 1", player_lane, score, game_state);
      end
   endtask

   task automatic test_score_sat();
      repeat (254) repeat (7) do_hop();
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL score_255: got %0d expected 255", score); end
      repeat (7) do_hop();
      checks++;
      if (score !== 8'd255 || player_lane !== 4'd0) begin
         errors++; $display("FAIL score_sat: got score=%0d lane=%0d expected 255 0", score, player_lane);
      end
   endtask

   task automatic test_score_hold();
      pulse_hit(1'b1);
      tick();
      checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL play_dead: got %0d expected 3", game_state); end
      repeat (60) tick();
      checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL dead_idle: got %0d expected 0", game_state); end
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL score_held: got %0d expected 255", score); end
      press();
      checks++;
      if (score !== 8'd0 || game_state !== 2'd1) begin
         errors++; $display("FAIL idle_press_clear: got score=%0d st=%0d expected 0 1", score, game_state);
      end
   endtask

   task automatic test_reset_mid_hop();
      press();
      tick();
      checks++; if (hop_offset !== 4'd1) begin errors++; $display("FAIL midhop_pre: got %0d expected 1", hop_offset); end
      sys_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (game_state !== 2'd0 || hop_offset !== 4'd0 || player_lane !== 4'd0 || score !== 8'd0) begin
         errors++; $display("FAIL midhop_reset: got st=%0d off=%0d lane=%0d score=%0d expected 0 0 0 0",
                            game_state, hop_offset, player_lane, score);
      end
      checks++; if (car_x[19:10] !== 10'd80) begin errors++; $display("FAIL midhop_car1: got %0d expected 80", car_x[19:10]); end
      sys_rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_car_wrap();
      do_reset();
      repeat (40) tick();
      checks++; if (car_x[19:10] !== 10'd0) begin errors++; $display("FAIL car1_at0: got %0d expected 0", car_x[19:10]); end
      tick();
      checks++; if (car_x[19:10] !== 10'd638) begin errors++; $display("FAIL car1_wrap: got %0d expected 638", car_x[19:10]); end
      repeat (598) tick();
      checks++; if (car_x[9:0] !== 10'd639) begin errors++; $display("FAIL car0_639: got %0d expected 639", car_x[9:0]); end
      tick();
      // After 640 ticks every lane has travelled a whole number of screen widths.
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (car_x[10*i +: 10] !== 10'(exp_n0[i])) begin
            errors++; $display("FAIL car640_%0d: got %0d expected %0d", i, car_x[10*i +: 10], exp_n0[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      press();
      // Press and frame tick land on the same edge while in PLAY.
      move = 1'b1;
      @(negedge clk);
      move = 1'b0;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      checks++;
      if (game_state !== 2'd2 || hop_offset !== 4'd0) begin
         errors++; $display("FAIL b2b_enter: got st=%0d off=%0d expected 2 0", game_state, hop_offset);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (car_x[10*i +: 10] !== 10'(exp_n1[i])) begin
            errors++; $display("FAIL b2b_car%0d: got %0d expected %0d", i, car_x[10*i +: 10], exp_n1[i]);
         end
      end
      tick();
      checks++; if (hop_offset !== 4'd1) begin errors++; $display("FAIL b2b_first_adv: got %0d expected 1", hop_offset); end
   endtask

   task automatic test_dead();
      pulse_hit(1'b0);
      tick();
      checks++;
      if (game_state !== 2'd2 || hop_offset !== 4'd2) begin
         errors++; $display("FAIL hit_no_display: got st=%0d off=%0d expected 2 2", game_state, hop_offset);
      end
      pulse_hit(1'b1);
      tick();
      checks++;
      if (game_state !== 2'd3 || hop_offset !== 4'd0) begin
         errors++; $display("FAIL hop_dead: got st=%0d off=%0d expected 3 0", game_state, hop_offset);
      end
      repeat (59) tick();
      checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL dead_59: got %0d expected 3", game_state); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (car_x[10*i +: 10] !== 10'(exp_n4[i])) begin
            errors++; $display("FAIL dead_frozen%0d: got %0d expected %0d", i, car_x[10*i +: 10], exp_n4[i]);
         end
      end
      tick();
      checks++;
      if (game_state !== 2'd0 || player_lane !== 4'd0) begin
         errors++; $display("FAIL dead_60: got st=%0d lane=%0d expected 0 0", game_state, player_lane);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (car_x[10*i +: 10] !== 10'(exp_n5[i])) begin
            errors++; $display("FAIL idle_car%0d: got %0d expected %0d", i, car_x[10*i +: 10], exp_n5[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_press_hold();
      test_hop();
      test_goal();
      test_score_sat();
      test_score_hold();
      test_reset_mid_hop();
      test_car_wrap();
      test_back_to_back();
      test_dead();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
